// File: rtl/instruction_fetch_stage.sv
// Instruction fetch stage: PC register, IF/ID pipeline register and fetch counter.
// The instruction memory is shared with data accesses, so a data access turns
// the fetch into a bubble. A taken branch seen on such a cycle is remembered and
// applied on the next real fetch. The instruction fetched on the redirect edge
// is a delay slot and is always delivered.
module instruction_fetch_stage #(
    parameter logic [15:0] RESET_PC  = 16'h0000,
    parameter logic [15:0] PC_STEP   = 16'h0001,
    parameter logic [15:0] NOP_INSTR = 16'b0000100000000000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall_i,
    input  logic        mem_conflict_i,
    input  logic        branch_taken_i,
    input  logic [15:0] branch_target_i,
    input  logic [15:0] instr_i,
    output logic [15:0] pc_o,
    output logic [15:0] ifid_instr_o,
    output logic [15:0] ifid_pc_o,
    output logic        ifid_valid_o,
    output logic [15:0] fetch_count_o
);

    typedef enum logic [1:0] {
        BOOT,
        RUN,
        STALL,
        BUBBLE
    } state_t;

    state_t      state_q, state_d;
    logic [15:0] pc_q, pc_d;
    logic [15:0] ifid_instr_q, ifid_instr_d;
    logic [15:0] ifid_pc_q, ifid_pc_d;
    logic        ifid_valid_q, ifid_valid_d;
    logic [15:0] count_q, count_d;
    logic        redir_pend_q, redir_pend_d;
    logic [15:0] redir_tgt_q, redir_tgt_d;

    // State register: asynchronous reset to BOOT with an empty IF/ID stage.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the values from before the edge, independent of statement order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= BOOT;
            pc_q         <= RESET_PC;
            ifid_instr_q <= NOP_INSTR;
            ifid_pc_q    <= 16'h0000;
            ifid_valid_q <= 1'b0;
            count_q      <= 16'h0000;
            redir_pend_q <= 1'b0;
            redir_tgt_q  <= 16'h0000;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            ifid_instr_q <= ifid_instr_d;
            ifid_pc_q    <= ifid_pc_d;
            ifid_valid_q <= ifid_valid_d;
            count_q      <= count_d;
            redir_pend_q <= redir_pend_d;
            redir_tgt_q  <= redir_tgt_d;
        end
    end

    // Next-state logic: stall beats memory conflict beats a normal fetch.
    always_comb begin
        // NOTE: every next-state signal defaults to "hold" before the case so no
        // path through the logic leaves one unassigned and infers a latch.
        state_d      = state_q;
        pc_d         = pc_q;
        ifid_instr_d = ifid_instr_q;
        ifid_pc_d    = ifid_pc_q;
        ifid_valid_d = ifid_valid_q;
        count_d      = count_q;
        redir_pend_d = redir_pend_q;
        redir_tgt_d  = redir_tgt_q;

        case (state_q)
            BOOT: begin
                // One settling edge after reset: no fetch, IF/ID stays a bubble.
                state_d = RUN;
            end
            default: begin
                if (stall_i) begin
                    // Everything freezes; decode re-asserts any branch afterwards.
                    state_d = STALL;
                end else if (mem_conflict_i) begin
                    state_d      = BUBBLE;
                    ifid_instr_d = NOP_INSTR;
                    ifid_valid_d = 1'b0;
                    if (branch_taken_i) begin
                        // Latest branch wins if one is already pending.
                        redir_pend_d = 1'b1;
                        redir_tgt_d  = branch_target_i;
                    end
                end else begin
                    state_d      = RUN;
                    ifid_instr_d = instr_i;
                    ifid_pc_d    = pc_q + PC_STEP;
                    ifid_valid_d = 1'b1;
                    count_d      = count_q + 16'h0001;
                    redir_pend_d = 1'b0;
                    if (branch_taken_i) begin
                        pc_d = branch_target_i;
                    end else if (redir_pend_q) begin
                        pc_d = redir_tgt_q;
                    end else begin
                        pc_d = pc_q + PC_STEP;
                    end
                end
            end
        endcase
    end

    assign pc_o          = pc_q;
    assign ifid_instr_o  = ifid_instr_q;
    assign ifid_pc_o     = ifid_pc_q;
    assign ifid_valid_o  = ifid_valid_q;
    assign fetch_count_o = count_q;

endmodule

// File: tb/tb_instruction_fetch_stage.sv
// Directed bench for instruction_fetch_stage. Instruction memory is modelled as
// word N = 16'h4900 + N. Each comparison checks the packed output vector
// {pc, ifid_instr, ifid_pc, ifid_valid, fetch_count} against a hand-computed value.
module tb_instruction_fetch_stage;

    localparam logic [15:0] NOP = 16'h0800;

    logic        clk;
    logic        rst;
    logic        stall_i;
    logic        mem_conflict_i;
    logic        branch_taken_i;
    logic [15:0] branch_target_i;
    logic [15:0] instr_i;
    logic [15:0] pc_o;
    logic [15:0] ifid_instr_o;
    logic [15:0] ifid_pc_o;
    logic        ifid_valid_o;
    logic [15:0] fetch_count_o;

    int vectors = 0;
    int miscompares = 0;

    instruction_fetch_stage dut (
        .clk             (clk),
        .rst             (rst),
        .stall_i         (stall_i),
        .mem_conflict_i  (mem_conflict_i),
        .branch_taken_i  (branch_taken_i),
        .branch_target_i (branch_target_i),
        .instr_i         (instr_i),
        .pc_o            (pc_o),
        .ifid_instr_o    (ifid_instr_o),
        .ifid_pc_o       (ifid_pc_o),
        .ifid_valid_o    (ifid_valid_o),
        .fetch_count_o   (fetch_count_o)
    );

    // Combinational instruction memory.
    assign instr_i = 16'h4900 + pc_o;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [64:0] obs();
        return {pc_o, ifid_instr_o, ifid_pc_o, ifid_valid_o, fetch_count_o};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        logic [64:0] exp;
        rst = 1'b1;
        stall_i = 1'b0;
        mem_conflict_i = 1'b0;
        branch_taken_i = 1'b0;
        branch_target_i = 16'h0000;
        #1 rst = 1'b0;
        #1;
        exp = {16'h0000, NOP, 16'h0000, 1'b0, 16'h0000};
        vectors++;
        if (obs() !== exp) begin
            miscompares++;
            $display("FAIL reset_async: got %h want %h", obs(), exp);
        end
        tick();
        rst = 1'b1;
        tick();  // boot edge: no fetch
        exp = {16'h0000, NOP, 16'h0000, 1'b0, 16'h0000};
        vectors++;
        if (obs() !== exp) begin
            miscompares++;
            $display("FAIL boot_edge: got %h want %h", obs(), exp);
        end
    endtask

    task automatic test_sequential();
        logic [64:0] exp;
        logic [15:0] n;
        for (int i = 0; i < 5; i++) begin
            tick();
            n = 16'(i);
            exp = {n + 16'h1, 16'h4900 + n, n + 16'h1, 1'b1, n + 16'h1};
            vectors++;
            if (obs() !== exp) begin
                miscompares++;
                $display("FAIL seq_fetch_%0d: got %h want %h", i, obs(), exp);
            end
        end
    endtask

    task automatic test_branch();
        logic [64:0] exp;
        branch_taken_i = 1'b1;
        branch_target_i = 16'h0020;
        tick();
        branch_taken_i = 1'b0;
        exp = {16'h0020, 16'h4905, 16'h0006, 1'b1, 16'h0006};
        vectors++;
        if (obs() !== exp) begin
            miscompares++;
            $display("FAIL branch_delay_slot: got %h want %h", obs(), exp);
        end
        tick();
        exp = {16'h0021, 16'h4920, 16'h0021, 1'b1, 16'h0007};
        vectors++;
        if (obs() !== exp) begin
            miscompares++;
            $display("FAIL branch_target_fetch: got %h want %h", obs(), exp);
        end
    endtask

    task automatic test_conflict();
        logic [64:0] exp;
        branch_taken_i = 1'b1;
        branch_target_i = 16'h0008;
        tick();
        exp = {16'h0008, 16'h4921, 16'h0022, 1'b1, 16'h0008};
        vectors++;
        if (obs() !== exp) begin
            miscompares++;
            $display("FAIL conflict_setup: got %h want %h", obs(), exp);
        end
        mem_conflict_i = 1'b1;
        branch_target_i = 16'h0030;
        for (int i = 0; i < 2; i++) begin
            tick();
            branch_taken_i = 1'b0;
            branch_target_i = 16'h0000;
            exp = {16'h0008, NOP, 16'h0022, 1'b0, 16'h0008};
            vectors++;
            if (obs() !== exp) begin
                miscompares++;
                $display("FAIL conflict_bubble_%0d: got %h want %h", i, obs(), exp);
            end
        end
        mem_conflict_i = 1'b0;
        tick();
        exp = {16'h0030, 16'h4908, 16'h0009, 1'b1, 16'h0009};
        vectors++;
        if (obs() !== exp) begin
            miscompares++;
            $display("FAIL conflict_pending_apply: got %h want %h", obs(), exp);
        end
        tick();
        exp = {16'h0031, 16'h4930, 16'h0031, 1'b1, 16'h000A};
        vectors++;
        if (obs() !== exp) begin
            miscompares++;
            $display("FAIL conflict_pending_clear: got %h want %h", obs(), exp);
        end
    endtask

    task automatic test_stall();
        logic [64:0] exp;
        branch_taken_i = 1'b1;
        branch_target_i = 16'h000C;
        tick();
        branch_taken_i = 1'b0;
        stall_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            // A branch during a stall must be ignored.
            branch_taken_i = (i == 1);
            branch_target_i = 16'h0077;
            tick();
            exp = {16'h000C, 16'h4931, 16'h0032, 1'b1, 16'h000B};
            vectors++;
            if (obs() !== exp) begin
                miscompares++;
                $display("FAIL stall_hold_%0d: got %h want %h", i, obs(), exp);
            end
        end
        branch_taken_i = 1'b0;
        stall_i = 1'b0;
        tick();
        exp = {16'h000D, 16'h490C, 16'h000D, 1'b1, 16'h000C};
        vectors++;
        if (obs() !== exp) begin
            miscompares++;
            $display("FAIL stall_resume: got %h want %h", obs(), exp);
        end
    endtask

    task automatic test_stall_conflict();
        logic [64:0] exp;
        stall_i = 1'b1;
        mem_conflict_i = 1'b1;
        tick();
        exp = {16'h000D, 16'h490C, 16'h000D, 1'b1, 16'h000C};
        vectors++;
        if (obs() !== exp) begin
            miscompares++;
            $display("FAIL stall_over_conflict: got %h want %h", obs(), exp);
        end
        stall_i = 1'b0;
        mem_conflict_i = 1'b0;
        tick();
        exp = {16'h000E, 16'h490D, 16'h000E, 1'b1, 16'h000D};
        vectors++;
        if (obs() !== exp) begin
            miscompares++;
            $display("FAIL stall_conflict_resume: got %h want %h", obs(), exp);
        end
    endtask

    task automatic test_reset_mid();
        logic [64:0] exp;
        mem_conflict_i = 1'b1;
        branch_taken_i = 1'b1;
        branch_target_i = 16'h0055;
        tick();
        mem_conflict_i = 1'b0;
        branch_taken_i = 1'b0;
        exp = {16'h000E, NOP, 16'h000E, 1'b0, 16'h000D};
        vectors++;
        if (obs() !== exp) begin
            miscompares++;
            $display("FAIL pending_bubble: got %h want %h", obs(), exp);
        end
        #2 rst = 1'b0;
        #1;
        exp = {16'h0000, NOP, 16'h0000, 1'b0, 16'h0000};
        vectors++;
        if (obs() !== exp) begin
            miscompares++;
            $display("FAIL reset_mid_pending: got %h want %h", obs(), exp);
        end
        rst = 1'b1;
        tick();
        exp = {16'h0000, NOP, 16'h0000, 1'b0, 16'h0000};
        vectors++;
        if (obs() !== exp) begin
            miscompares++;
            $display("FAIL reboot_edge: got %h want %h", obs(), exp);
        end
        tick();
        exp = {16'h0001, 16'h4900, 16'h0001, 1'b1, 16'h0001};
        vectors++;
        if (obs() !== exp) begin
            miscompares++;
            $display("FAIL reboot_pending_discarded: got %h want %h", obs(), exp);
        end
    endtask

    task automatic test_wrap();
        logic [64:0] exp;
        for (int i = 0; i < 65534; i++) tick();
        exp = {16'hFFFF, 16'h48FE, 16'hFFFF, 1'b1, 16'hFFFF};
        vectors++;
        if (obs() !== exp) begin
            miscompares++;
            $display("FAIL wrap_preload: got %h want %h", obs(), exp);
        end
        tick();
        exp = {16'h0000, 16'h48FF, 16'h0000, 1'b1, 16'h0000};
        vectors++;
        if (obs() !== exp) begin
            miscompares++;
            $display("FAIL wrap_pc_count: got %h want %h", obs(), exp);
        end
    endtask

    task automatic test_reset_mid_stall();
        logic [64:0] exp;
        stall_i = 1'b1;
        tick();
        #2 rst = 1'b0;
        #1;
        exp = {16'h0000, NOP, 16'h0000, 1'b0, 16'h0000};
        vectors++;
        if (obs() !== exp) begin
            miscompares++;
            $display("FAIL reset_mid_stall: got %h want %h", obs(), exp);
        end
        stall_i = 1'b0;
        rst = 1'b1;
        tick();
        tick();
        exp = {16'h0001, 16'h4900, 16'h0001, 1'b1, 16'h0001};
        vectors++;
        if (obs() !== exp) begin
            miscompares++;
            $display("FAIL restart_after_stall_reset: got %h want %h", obs(), exp);
        end
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_branch();
        test_conflict();
        test_stall();
        test_stall_conflict();
        test_reset_mid();
        test_wrap();
        test_reset_mid_stall();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    // Watchdog so the run always ends.
    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/instruction_fetch_stage.md
INSTRUCTION_FETCH_STAGE -- requirements
Module: instruction_fetch_stage

Interface
REQ-001 Parameter RESET_PC, 16'h0000, PC value loaded on reset.
REQ-002 Parameter PC_STEP, 16'h0001, increment applied to PC per fetched instruction.
REQ-003 Parameter NOP_INSTR, 16'b0000100000000000, instruction word inserted as a bubble.
REQ-004 clk  input  1  rising-edge clock.
REQ-005 rst  input  1  reset, asynchronous, active-low.
REQ-006 stall_i  input  1  hazard stall from decode; holds PC and the IF/ID register.
REQ-007 mem_conflict_i  input  1  data access occupies the shared memory this cycle; no fetch is possible.
REQ-008 branch_taken_i  input  1  one-cycle pulse from decode: a taken branch or jump.
REQ-009 branch_target_i  input  16  redirect target, valid when branch_taken_i=1.
REQ-010 instr_i  input  16  instruction word from instruction memory for the current pc_o (combinational read).
REQ-011 pc_o  output  16  fetch address to instruction memory, driven directly from the PC register.
REQ-012 ifid_instr_o  output  16  registered instruction for decode.
REQ-013 ifid_pc_o  output  16  registered PC+PC_STEP of the instruction in ifid_instr_o.
REQ-014 ifid_valid_o  output  1  1 = ifid_instr_o is a real fetch; 0 = bubble.
REQ-015 fetch_count_o  output  16  count of completed fetches; wraps 16'hFFFF->16'h0000.

Function
REQ-016 States: BOOT, RUN, STALL, BUBBLE; the state is held in a register and is updated on the rising clock edge.
REQ-017 BOOT is entered on reset; the first edge after rst deasserts moves BOOT->RUN without fetching, PC held, IF/ID = bubble.
REQ-018 Edge priority in RUN/STALL/BUBBLE: stall_i > mem_conflict_i > normal fetch.
REQ-019 Fetch edge (stall_i=0, mem_conflict_i=0): ifid_instr_o<=instr_i, ifid_pc_o<=pc_o+PC_STEP, ifid_valid_o<=1, fetch_count_o+1, state->RUN.
REQ-020 Fetch edge PC update: if branch_taken_i=1 or redirect_pending=1, then pc<=branch_target_i when branch_taken_i=1, else pc<=pending target; otherwise pc<=pc+PC_STEP.
REQ-021 Delay slot: the instruction fetched on the redirect edge is the delay slot and is delivered with ifid_valid_o=1; it is never squashed.
REQ-022 Conflict edge (stall_i=0, mem_conflict_i=1): IF/ID<=NOP_INSTR, ifid_pc_o unchanged, ifid_valid_o<=0, PC held, count held, state->BUBBLE.
REQ-023 Conflict edge with branch_taken_i=1: the target is latched into redirect_pending; it is applied on the next fetch edge (REQ-020).
REQ-024 Stall edge (stall_i=1): PC, IF/ID, count and redirect_pending all held; branch_taken_i ignored (decode re-asserts it after the stall); state->STALL.
REQ-025 A new branch_taken_i while redirect_pending=1 overwrites the pending target (latest wins).
REQ-026 PC arithmetic is 16-bit modulo; 16'hFFFF+PC_STEP wraps with no flag.
REQ-027 pc_o changes only on clock edges or on reset; there is no combinational path from any input to pc_o.
REQ-028 ifid_pc_o for bubbles retains its last value; decode keys only on ifid_valid_o.

Reset
REQ-029 rst=0 asynchronously forces pc_o=RESET_PC, ifid_instr_o=NOP_INSTR, ifid_pc_o=16'h0000, ifid_valid_o=0, fetch_count_o=0, redirect_pending=0, state=BOOT.
REQ-030 Reset asserted mid-stall, mid-conflict or with a redirect pending discards all state; the sequence restarts at REQ-017.

Verification
REQ-031 Release reset, no stalls, memory word at N = 16'h4900+N -> first valid IF/ID after the 2nd edge: instr 16'h4900, ifid_pc 1; then 16'h4901, ifid_pc 2; pc_o steps 0,0,1,2,...
REQ-032 pc_o=5, branch_taken_i=1 with target 16'h0020 -> the delay slot at 5 is delivered valid; next pc_o=16'h0020; fetch_count_o increments by 1 per edge.
REQ-033 pc_o=8, mem_conflict_i=1 for 2 cycles with branch_taken_i=1 (target 16'h0030) in the first -> two bubbles (valid=0, instr NOP), pc_o held 8; on the next edge the delay slot at 8 is delivered valid and pc_o=16'h0030.
REQ-034 stall_i=1 for 3 cycles at pc_o=12 -> pc_o, ifid_instr_o, ifid_valid_o and fetch_count_o are constant; the fetch at 12 resumes on the first edge after stall_i falls.
REQ-035 stall_i=1 and mem_conflict_i=1 together -> stall behaviour (REQ-024); no bubble is inserted.
REQ-036 PC at 16'hFFFF, normal fetch -> pc_o=16'h0000; fetch_count_o preloaded to 16'hFFFF wraps to 0; rst pulsed low mid-sequence -> the REQ-029 values appear immediately, without a clock edge.
